// File: rtl/riscv_irq_ctrl.sv
// Machine-mode interrupt controller: masks peripheral requests with mie, picks the
// lowest pending line, raises a trap request with its mcause and holds that line
// until mret, then returns a one-hot acknowledge to the peripheral.
module riscv_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               exception_i,
    input  logic               stall_i,
    input  logic               mret_i,
    output logic               irq_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ret_o
);

    localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [0:0] {StIdle, StService} state_e;

    state_e            state_q;
    logic [IdxW-1:0]   held_idx_q;

    logic [NUM_IRQ-1:0] pend;
    logic [IdxW-1:0]    sel;
    logic [IdxW-1:0]    idx;
    logic               accept;
    logic [4:0]         cause_code;

    // Only mie[16 +: NUM_IRQ] matters; the rest is folded here to mark it intentionally unused.
    logic unused_mie;
    assign unused_mie = ^mie_i;

    assign pend = irq_req_i & mie_i[16 +: NUM_IRQ];

    // Fixed priority: lowest set index wins; zero when nothing is pending.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = IdxW'(i);
            end
        end
    end

    // Take decision and combinational trap/ack outputs.
    always_comb begin
        accept      = (state_q == StIdle) & (|pend) & ~exception_i & ~stall_i & ~rst_i;
        irq_o       = accept;
        idx         = (state_q == StService) ? held_idx_q : sel;
        cause_code  = 5'd16 + 5'(idx);
        irq_cause_o = {1'b1, 26'b0, cause_code};
        irq_ret_o   = '0;
        if ((state_q == StService) && mret_i && !rst_i) begin
            irq_ret_o = NUM_IRQ'(1) << held_idx_q;
        end
    end

    // Service FSM: latch the winning line on accept, release it on mret.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            held_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        held_idx_q <= sel;
                        state_q    <= StService;
                    end
                end
                StService: begin
                    if (mret_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
